id_ex_stage_reg: RTL and testbench



---
 rtl/id_ex_stage_reg.sv | 183 ++++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline boundary: captures decoded operands and control, inserts flush and
// load-use bubbles, registers EX forwarding selects and counts hazard bubbles.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CMD_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_val1,
    input  logic [DATA_W-1:0] in_reg2,
    input  logic [DATA_W-1:0] in_val2,
    input  logic [REG_AW-1:0] in_src1,
    input  logic [REG_AW-1:0] in_src2,
    input  logic              in_src2_used,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_wb_en,
    input  logic [1:0]        in_mem_sig,
    input  logic [1:0]        in_br_type,
    input  logic [CMD_W-1:0]  in_exe_cmd,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_val1,
    output logic [DATA_W-1:0] ex_reg2,
    output logic [DATA_W-1:0] ex_val2,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_wb_en,
    output logic [1:0]        ex_mem_sig,
    output logic [1:0]        ex_br_type,
    output logic [CMD_W-1:0]  ex_exe_cmd,
    output logic [1:0]        ex_fwd1_sel,
    output logic [1:0]        ex_fwd2_sel,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    logic              ex_valid_reg;
    logic [DATA_W-1:0] ex_pc_reg;
    logic [DATA_W-1:0] ex_val1_reg;
    logic [DATA_W-1:0] ex_reg2_reg;
    logic [DATA_W-1:0] ex_val2_reg;
    logic [REG_AW-1:0] ex_dest_reg;
    logic              ex_wb_en_reg;
    logic [1:0]        ex_mem_sig_reg;
    logic [1:0]        ex_br_type_reg;
    logic [CMD_W-1:0]  ex_exe_cmd_reg;
    logic [1:0]        ex_fwd1_sel_reg;
    logic [1:0]        ex_fwd2_sel_reg;
    logic [CNT_W-1:0]  stall_count_reg;

    logic              load_in_ex;
    logic              hazard_next;
    logic              bubble_next;
    logic              ex_writes_reg;
    logic              mem_writes_reg;
    logic [1:0]        fwd1_next;
    logic [1:0]        fwd2_next;
    logic [CNT_W-1:0]  stall_count_next;

    // A load in EX cannot supply its data until it leaves MEM, so a consumer in ID must wait one cycle.
    always_comb begin
        load_in_ex  = ex_valid_reg && ex_mem_sig_reg[0] && (ex_dest_reg != '0);
        hazard_next = 1'b0;
        if (!flush && in_valid && load_in_ex) begin
            hazard_next = (ex_dest_reg == in_src1) ||
                          (in_src2_used && (ex_dest_reg == in_src2));
        end
        bubble_next = flush || hazard_next || !in_valid;
    end

    assign ex_writes_reg  = ex_valid_reg && ex_wb_en_reg && (ex_dest_reg != '0);
    assign mem_writes_reg = mem_wb_en && (mem_dest != '0);

    // One select generator per source operand; index 0 is rs, index 1 is rt.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic [REG_AW-1:0] src;
            logic              used;
            logic [1:0]        sel;

            if (gi == 0) begin : g_rs
                assign src  = in_src1;
                assign used = 1'b1;
            end else begin : g_rt
                assign src  = in_src2;
                assign used = in_src2_used;
            end

            // The younger producer (currently in EX) wins over the older one in MEM.
            always_comb begin
                sel = FWD_NONE;
                if (used) begin
                    if (ex_writes_reg && (ex_dest_reg == src)) begin
                        sel = FWD_MEM;
                    end else if (mem_writes_reg && (mem_dest == src)) begin
                        sel = FWD_WB;
                    end
                end
            end
        end
    endgenerate

    assign fwd1_next = g_fwd[0].sel;
    assign fwd2_next = g_fwd[1].sel;

    always_comb begin
        stall_count_next = stall_count_reg;
        if (hazard_next && (stall_count_reg != {CNT_W{1'b1}})) begin
            stall_count_next = stall_count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg    <= 1'b0;
            ex_pc_reg       <= '0;
            ex_val1_reg     <= '0;
            ex_reg2_reg     <= '0;
            ex_val2_reg     <= '0;
            ex_dest_reg     <= '0;
            ex_wb_en_reg    <= 1'b0;
            ex_mem_sig_reg  <= '0;
            ex_br_type_reg  <= '0;
            ex_exe_cmd_reg  <= '0;
            ex_fwd1_sel_reg <= FWD_NONE;
            ex_fwd2_sel_reg <= FWD_NONE;
            stall_count_reg <= '0;
        end else if (!freeze) begin
            // Data fields are don't-care inside a bubble, so they always follow ID.
            ex_pc_reg       <= in_pc;
            ex_val1_reg     <= in_val1;
            ex_reg2_reg     <= in_reg2;
            ex_val2_reg     <= in_val2;
            stall_count_reg <= stall_count_next;
            if (bubble_next) begin
                ex_valid_reg    <= 1'b0;
                ex_dest_reg     <= '0;
                ex_wb_en_reg    <= 1'b0;
                ex_mem_sig_reg  <= '0;
                ex_br_type_reg  <= '0;
                ex_exe_cmd_reg  <= '0;
                ex_fwd1_sel_reg <= FWD_NONE;
                ex_fwd2_sel_reg <= FWD_NONE;
            end else begin
                ex_valid_reg    <= 1'b1;
                ex_dest_reg     <= in_dest;
                ex_wb_en_reg    <= in_wb_en;
                ex_mem_sig_reg  <= in_mem_sig;
                ex_br_type_reg  <= in_br_type;
                ex_exe_cmd_reg  <= in_exe_cmd;
                ex_fwd1_sel_reg <= fwd1_next;
                ex_fwd2_sel_reg <= fwd2_next;
            end
        end
    end

    assign ex_valid     = ex_valid_reg;
    assign ex_pc        = ex_pc_reg;
    assign ex_val1      = ex_val1_reg;
    assign ex_reg2      = ex_reg2_reg;
    assign ex_val2      = ex_val2_reg;
    assign ex_dest      = ex_dest_reg;
    assign ex_wb_en     = ex_wb_en_reg;
    assign ex_mem_sig   = ex_mem_sig_reg;
    assign ex_br_type   = ex_br_type_reg;
    assign ex_exe_cmd   = ex_exe_cmd_reg;
    assign ex_fwd1_sel  = ex_fwd1_sel_reg;
    assign ex_fwd2_sel  = ex_fwd2_sel_reg;
    assign hazard_stall = hazard_next;
    assign stall_count  = stall_count_reg;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural model of the ID/EX boundary.
module tb_id_ex_stage_reg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, freeze, flush, in_valid;
    logic [DW-1:0] in_pc, in_val1, in_reg2, in_val2;
    logic [AW-1:0] in_src1, in_src2, in_dest, mem_dest;
    logic          in_src2_used, in_wb_en, mem_wb_en;
    logic [1:0]    in_mem_sig, in_br_type;
    logic [CW-1:0] in_exe_cmd;

    logic          ex_valid, ex_wb_en, hazard_stall;
    logic [DW-1:0] ex_pc, ex_val1, ex_reg2, ex_val2;
    logic [AW-1:0] ex_dest;
    logic [1:0]    ex_mem_sig, ex_br_type, ex_fwd1_sel, ex_fwd2_sel;
    logic [CW-1:0] ex_exe_cmd;
    logic [15:0]   stall_count;

    logic          s_valid, s_wb_en, s_hazard;
    logic [DW-1:0] s_pc, s_val1, s_reg2, s_val2;
    logic [AW-1:0] s_dest;
    logic [1:0]    s_mem_sig, s_br_type, s_fwd1, s_fwd2;
    logic [CW-1:0] s_exe_cmd;
    logic [1:0]    s_count;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
        .in_pc(in_pc), .in_val1(in_val1), .in_reg2(in_reg2), .in_val2(in_val2),
        .in_src1(in_src1), .in_src2(in_src2), .in_src2_used(in_src2_used),
        .in_dest(in_dest), .in_wb_en(in_wb_en), .in_mem_sig(in_mem_sig),
        .in_br_type(in_br_type), .in_exe_cmd(in_exe_cmd),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_val1(ex_val1), .ex_reg2(ex_reg2),
        .ex_val2(ex_val2), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_sig(ex_mem_sig),
        .ex_br_type(ex_br_type), .ex_exe_cmd(ex_exe_cmd),
        .ex_fwd1_sel(ex_fwd1_sel), .ex_fwd2_sel(ex_fwd2_sel),
        .hazard_stall(hazard_stall), .stall_count(stall_count)
    );

    id_ex_stage_reg #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
        .in_pc(in_pc), .in_val1(in_val1), .in_reg2(in_reg2), .in_val2(in_val2),
        .in_src1(in_src1), .in_src2(in_src2), .in_src2_used(in_src2_used),
        .in_dest(in_dest), .in_wb_en(in_wb_en), .in_mem_sig(in_mem_sig),
        .in_br_type(in_br_type), .in_exe_cmd(in_exe_cmd),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .ex_valid(s_valid), .ex_pc(s_pc), .ex_val1(s_val1), .ex_reg2(s_reg2),
        .ex_val2(s_val2), .ex_dest(s_dest), .ex_wb_en(s_wb_en), .ex_mem_sig(s_mem_sig),
        .ex_br_type(s_br_type), .ex_exe_cmd(s_exe_cmd),
        .ex_fwd1_sel(s_fwd1), .ex_fwd2_sel(s_fwd2),
        .hazard_stall(s_hazard), .stall_count(s_count)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: the instruction that should currently sit in EX, plus a bubble tally.
    logic          m_valid = 0, m_wb = 0;
    logic [DW-1:0] m_pc = 0, m_val1 = 0, m_reg2 = 0, m_val2 = 0;
    logic [AW-1:0] m_dest = 0;
    logic [1:0]    m_mem = 0, m_br = 0, m_f1 = 0, m_f2 = 0;
    logic [CW-1:0] m_cmd = 0;
    int unsigned   m_bubbles = 0;

    function automatic logic model_hazard();
        logic dep;
        dep = (m_dest == in_src1) || (in_src2_used && m_dest == in_src2);
        return !flush && in_valid && m_valid && m_mem[0] && (m_dest != 0) && dep;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [AW-1:0] src, input logic used);
        if (!used) return 2'b00;
        if (m_valid && m_wb && m_dest != 0 && m_dest == src) return 2'b01;
        if (mem_wb_en && mem_dest != 0 && mem_dest == src) return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        logic haz;
        logic [1:0] f1, f2;
        if (rst) begin
            {m_valid, m_wb, m_pc, m_val1, m_reg2, m_val2} = '0;
            {m_dest, m_mem, m_br, m_f1, m_f2, m_cmd} = '0;
            m_bubbles = 0;
        end else if (!freeze) begin
            haz = model_hazard();
            f1  = model_fwd(in_src1, 1'b1);
            f2  = model_fwd(in_src2, in_src2_used);
            m_pc = in_pc; m_val1 = in_val1; m_reg2 = in_reg2; m_val2 = in_val2;
            if (flush || haz || !in_valid) begin
                {m_valid, m_wb, m_dest, m_mem, m_br, m_cmd, m_f1, m_f2} = '0;
            end else begin
                m_valid = 1'b1; m_wb = in_wb_en; m_dest = in_dest; m_mem = in_mem_sig;
                m_br = in_br_type; m_cmd = in_exe_cmd; m_f1 = f1; m_f2 = f2;
            end
            if (haz) m_bubbles++;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("ex_valid", 64'(ex_valid), 64'(m_valid));
            chk("ex_dest", 64'(ex_dest), 64'(m_dest));
            chk("ex_wb_en", 64'(ex_wb_en), 64'(m_wb));
            chk("ex_mem_sig", 64'(ex_mem_sig), 64'(m_mem));
            chk("ex_br_type", 64'(ex_br_type), 64'(m_br));
            chk("ex_exe_cmd", 64'(ex_exe_cmd), 64'(m_cmd));
            chk("ex_fwd1_sel", 64'(ex_fwd1_sel), 64'(m_f1));
            chk("ex_fwd2_sel", 64'(ex_fwd2_sel), 64'(m_f2));
            chk("hazard_stall", 64'(hazard_stall), 64'(model_hazard()));
            chk("stall_count", 64'(stall_count), 64'((m_bubbles > 65535) ? 65535 : m_bubbles));
            chk("sat_stall_count", 64'(s_count), 64'((m_bubbles > 3) ? 3 : m_bubbles));
            chk("sat_ex_valid", 64'(s_valid), 64'(m_valid));
            if (m_valid) begin
                chk("ex_pc", 64'(ex_pc), 64'(m_pc));
                chk("ex_val1", 64'(ex_val1), 64'(m_val1));
                chk("ex_reg2", 64'(ex_reg2), 64'(m_reg2));
                chk("ex_val2", 64'(ex_val2), 64'(m_val2));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        freeze = 0; flush = 0; in_valid = 0;
        in_pc = 0; in_val1 = 0; in_reg2 = 0; in_val2 = 0;
        in_src1 = 0; in_src2 = 0; in_src2_used = 0; in_dest = 0;
        in_wb_en = 0; in_mem_sig = 0; in_br_type = 0; in_exe_cmd = 0;
        mem_dest = 0; mem_wb_en = 0;
    endtask

    task automatic present(input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic used2,
                           input logic [AW-1:0] d, input logic wb, input logic [1:0] ms);
        in_valid = 1; in_src1 = s1; in_src2 = s2; in_src2_used = used2;
        in_dest = d; in_wb_en = wb; in_mem_sig = ms;
    endtask

    initial begin
        idle_inputs();
        rst = 1; freeze = 1;
        tick(); tick();
        check_en = 1;
        chk("reset_valid", 64'(ex_valid), 64'd0);
        chk("reset_count", 64'(stall_count), 64'd0);
        chk("reset_fwd", 64'({ex_fwd1_sel, ex_fwd2_sel}), 64'd0);
        chk("reset_cmd", 64'(ex_exe_cmd), 64'd0);
        rst = 0; freeze = 0;

        // Passthrough
        present(0, 0, 0, 3, 1, 2'b00);
        in_pc = 32'h40; in_val1 = 32'h11; in_val2 = 32'h22; in_exe_cmd = 4;
        tick();
        chk("pass_valid", 64'(ex_valid), 64'd1);
        chk("pass_pc", 64'(ex_pc), 64'h40);
        chk("pass_val1", 64'(ex_val1), 64'h11);
        chk("pass_val2", 64'(ex_val2), 64'h22);
        chk("pass_dest", 64'(ex_dest), 64'd3);
        chk("pass_cmd", 64'(ex_exe_cmd), 64'd4);
        chk("pass_fwd", 64'({ex_fwd1_sel, ex_fwd2_sel}), 64'd0);

        // Load-use: lw r5, then add using r5
        present(0, 0, 0, 5, 1, 2'b01);
        tick();
        present(5, 0, 1, 6, 1, 2'b00);
        #1 chk("lu_hazard", 64'(hazard_stall), 64'd1);
        tick();
        chk("lu_bubble_valid", 64'(ex_valid), 64'd0);
        chk("lu_count", 64'(stall_count), 64'd1);
        mem_dest = 5; mem_wb_en = 1;
        #1 chk("lu_hazard_clear", 64'(hazard_stall), 64'd0);
        tick();
        chk("lu_add_valid", 64'(ex_valid), 64'd1);
        chk("lu_add_dest", 64'(ex_dest), 64'd6);
        chk("lu_add_fwd1", 64'(ex_fwd1_sel), 64'd2);

        // Forward priority: EX producer beats MEM producer; unused rt never forwards
        mem_wb_en = 0;
        present(0, 0, 0, 7, 1, 2'b00);
        tick();
        mem_dest = 7; mem_wb_en = 1;
        present(7, 7, 0, 8, 1, 2'b00);
        tick();
        chk("prio_fwd1", 64'(ex_fwd1_sel), 64'd1);
        chk("prio_fwd2", 64'(ex_fwd2_sel), 64'd0);
        present(0, 0, 0, 0, 1, 2'b00);
        mem_dest = 0;
        tick();
        present(0, 0, 1, 9, 1, 2'b00);
        tick();
        chk("r0_fwd", 64'({ex_fwd1_sel, ex_fwd2_sel}), 64'd0);

        // Flush wins over hazard; freeze wins over flush
        mem_wb_en = 0;
        present(0, 0, 0, 9, 1, 2'b01);
        tick();
        present(9, 0, 0, 10, 1, 2'b00);
        flush = 1;
        #1 chk("flush_hazard", 64'(hazard_stall), 64'd0);
        tick();
        chk("flush_valid", 64'(ex_valid), 64'd0);
        chk("flush_count", 64'(stall_count), 64'd1);
        flush = 0;
        present(0, 0, 0, 10, 1, 2'b00);
        tick();
        present(0, 0, 0, 11, 0, 2'b10);
        freeze = 1; flush = 1;
        tick();
        chk("freeze_dest", 64'(ex_dest), 64'd10);
        chk("freeze_valid", 64'(ex_valid), 64'd1);
        freeze = 0; flush = 0;

        // Saturation on the 2-bit counter copy
        rst = 1; tick(); rst = 0;
        for (int k = 0; k < 5; k++) begin
            present(0, 0, 0, 5, 1, 2'b01);
            tick();
            present(0, 5, 1, 6, 1, 2'b00);
            tick();
            chk("sat_seq", 64'(s_count), (k < 3) ? 64'(k + 1) : 64'd3);
            chk("wide_seq", 64'(stall_count), 64'(k + 1));
        end

        // Random traffic; small register range so dependencies are frequent
        for (int c = 0; c < 4000; c++) begin
            rst          = ($urandom_range(0, 99) < 2);
            freeze       = ($urandom_range(0, 99) < 12);
            flush        = ($urandom_range(0, 99) < 10);
            in_valid     = ($urandom_range(0, 99) < 85);
            in_pc        = $urandom;
            in_val1      = $urandom;
            in_reg2      = $urandom;
            in_val2      = $urandom;
            in_src1      = AW'($urandom_range(0, 3));
            in_src2      = AW'($urandom_range(0, 3));
            in_src2_used = 1'($urandom);
            in_dest      = AW'($urandom_range(0, 3));
            in_wb_en     = 1'($urandom);
            in_mem_sig   = 2'($urandom);
            in_br_type   = 2'($urandom);
            in_exe_cmd   = CW'($urandom);
            mem_dest     = AW'($urandom_range(0, 3));
            mem_wb_en    = 1'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
